decode_issue_queue: RTL

Producer side of the decode-to-issue handshake. Buffers decoded instructions from the decode stage in a small FIFO and presents them to the issue stage with a valid/ack handshake, together with the original instruction word and the control-flow flag. It holds issue after a control-flow instruction until the branch unit reports resolution, and it drops all buffered instructions on flush.

---
 rtl/decode_issue_queue.sv | 71 +++++++
 1 files changed

// File: rtl/decode_issue_queue.sv
// decode_issue_queue: decode-to-issue FIFO that holds issue after a control-flow instruction until it is resolved
module decode_issue_queue #(
  parameter type scoreboard_entry_t = logic [63:0],
  parameter int unsigned Depth = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         stall_i,
  input  scoreboard_entry_t            instr_i,
  input  logic [31:0]                  orig_instr_i,
  input  logic                         is_ctrl_flow_i,
  input  logic                         instr_valid_i,
  output logic                         instr_ready_o,
  output scoreboard_entry_t            decoded_instr_o,
  output logic [31:0]                  orig_instr_o,
  output logic                         is_ctrl_flow_o,
  output logic                         decoded_instr_valid_o,
  input  logic                         decoded_instr_ack_i,
  input  logic                         resolve_branch_i,
  output logic [$clog2(Depth+1)-1:0]   occupancy_o,
  output logic                         branch_wait_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT_RESOLVE = 1'b1;
  scoreboard_entry_t instr_q [Depth];
  logic [31:0]       orig_q [Depth];
  logic [Depth-1:0]  ctrl_q;
  logic [PtrW-1:0]   wr_ptr, rd_ptr;
  logic [CntW-1:0]   count;
  logic [0:0]        state;
  logic              push, pop;
  assign instr_ready_o         = count != CntW'(Depth);
  assign decoded_instr_valid_o = (count != '0) && (state == IDLE) && !stall_i;
  assign push                  = instr_valid_i && instr_ready_o && !flush_i;
  assign pop                   = decoded_instr_valid_o && decoded_instr_ack_i;
  assign decoded_instr_o       = instr_q[rd_ptr];
  assign orig_instr_o          = orig_q[rd_ptr];
  assign is_ctrl_flow_o        = ctrl_q[rd_ptr];
  assign occupancy_o           = count;
  assign branch_wait_o         = state == WAIT_RESOLVE;
  // Storage carries no reset; only the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_q[wr_ptr] <= instr_i;
      orig_q[wr_ptr]  <= orig_instr_i;
      ctrl_q[wr_ptr]  <= is_ctrl_flow_i;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= IDLE;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= IDLE;
    end else begin
      wr_ptr <= push ? wr_ptr + PtrW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + PtrW'(1) : rd_ptr;
      count  <= count + CntW'(push) - CntW'(pop);
      state  <= (state == IDLE) ? ((pop && is_ctrl_flow_o) ? WAIT_RESOLVE : IDLE)
                                : (resolve_branch_i ? IDLE : WAIT_RESOLVE);
    end
  end
endmodule
